// File: rtl/dispatch_ctrl_pkg.sv
// Shared decode/dispatch constants: station select encodings,
// payload width and the queue entry layout.
package dispatch_ctrl_pkg;

  localparam int UOP_WIDTH = 64;
  localparam int RS_SEL_W  = 2;

  typedef enum logic [RS_SEL_W-1:0] {
    RS_NONE = 2'd0,
    RS_ALU  = 2'd1,
    RS_MUL  = 2'd2,
    RS_LDST = 2'd3
  } rs_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic                 illegal;
    rs_sel_e              rs_sel;
    logic [UOP_WIDTH-1:0] uop;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Decoder-side and station-side handshake bundle of the dispatch queue.
// slave = dispatch block, master = decoder plus stations.
interface dispatch_ctrl_if;
  import dispatch_ctrl_pkg::*;

  logic                 dec_valid;
  logic                 dec_ready;
  logic [UOP_WIDTH-1:0] dec_uop;
  logic [RS_SEL_W-1:0]  dec_rs_sel;
  logic                 dec_illegal;
  logic                 alu_valid;
  logic                 alu_ready;
  logic                 mul_valid;
  logic                 mul_ready;
  logic                 ldst_valid;
  logic                 ldst_ready;
  logic [UOP_WIDTH-1:0] uop;

  modport slave (
    input  dec_valid, dec_uop, dec_rs_sel, dec_illegal,
    input  alu_ready, mul_ready, ldst_ready,
    output dec_ready, alu_valid, mul_valid, ldst_valid, uop
  );

  modport master (
    output dec_valid, dec_uop, dec_rs_sel, dec_illegal,
    output alu_ready, mul_ready, ldst_ready,
    input  dec_ready, alu_valid, mul_valid, ldst_valid, uop
  );

endinterface

// File: rtl/dispatch_fifo.sv
// Generic DEPTH x W circular buffer with push/pop/flush and occupancy.
// Flush wins over push and pop in the same cycle.
module dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_wdata,
  output logic [W-1:0]     o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_head];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Payload storage needs no reset; reads are qualified by o_empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// In-order dispatch queue: steers the head micro-op to ALU/MUL/LDST and
// halts on illegal ops until flush. Optional counters: DISPATCH_PERF_EN.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  dispatch_ctrl_if.slave   bus,
  output logic [CNT_W-1:0] o_count,
`ifdef DISPATCH_PERF_EN
  output logic [31:0]      o_stall_full_cnt,
  output logic [31:0]      o_stall_rs_cnt,
`endif
  output logic             o_illegal_trap
);

  state_e r_state;
  state_e w_state_nxt;
  entry_t w_wr;
  entry_t w_head;
  logic   w_empty;
  logic   w_full;
  logic   w_push;
  logic   w_pop;
  logic   w_run;
  logic   w_alu_v;
  logic   w_mul_v;
  logic   w_ldst_v;
  logic   w_trap;

  assign w_run  = (r_state == ST_RUN);
  assign w_wr   = '{illegal: bus.dec_illegal,
                    rs_sel:  rs_sel_e'(bus.dec_rs_sel),
                    uop:     bus.dec_uop};
  assign w_push = bus.dec_valid && bus.dec_ready;

  dispatch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wr),
    .o_rdata (w_head),
    .o_count (o_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_alu_v     = 1'b0;
    w_mul_v     = 1'b0;
    w_ldst_v    = 1'b0;
    w_trap      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (!w_empty) begin
          if (w_head.illegal) begin
            w_trap      = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            unique case (w_head.rs_sel)
              RS_ALU:  w_alu_v  = 1'b1;
              RS_MUL:  w_mul_v  = 1'b1;
              RS_LDST: w_ldst_v = 1'b1;
              RS_NONE: w_pop    = 1'b1;
            endcase
          end
        end
      end
      ST_HALT: ;
    endcase
    if ((w_alu_v && bus.alu_ready) ||
        (w_mul_v && bus.mul_ready) ||
        (w_ldst_v && bus.ldst_ready))
      w_pop = 1'b1;
    if (i_flush) w_state_nxt = ST_RUN;
  end

  assign bus.dec_ready  = w_run && !w_full;
  assign bus.alu_valid  = w_alu_v;
  assign bus.mul_valid  = w_mul_v;
  assign bus.ldst_valid = w_ldst_v;
  assign bus.uop        = w_empty ? '0 : w_head.uop;
  assign o_illegal_trap = w_trap;

`ifdef DISPATCH_PERF_EN
  logic [31:0] r_stall_full;
  logic [31:0] r_stall_rs;
  logic        w_sf;
  logic        w_sr;

  assign w_sf = w_run && bus.dec_valid && !bus.dec_ready;
  assign w_sr = (w_alu_v && !bus.alu_ready) ||
                (w_mul_v && !bus.mul_ready) ||
                (w_ldst_v && !bus.ldst_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_full <= '0;
      r_stall_rs   <= '0;
    end else begin
      if (w_sf && r_stall_full != '1) r_stall_full <= r_stall_full + 1'b1;
      if (w_sr && r_stall_rs != '1)   r_stall_rs   <= r_stall_rs + 1'b1;
    end
  end

  assign o_stall_full_cnt = r_stall_full;
  assign o_stall_rs_cnt   = r_stall_rs;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed scenarios plus random traffic,
// every cycle checked against a queue-based reference model.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [CNT_W-1:0] count;
  logic trap;
`ifdef DISPATCH_PERF_EN
  logic [31:0] sf_cnt;
  logic [31:0] sr_cnt;
`endif

  always #5 clk = ~clk;

  dispatch_ctrl_if ifc();

  dispatch_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_flush          (flush),
    .bus              (ifc.slave),
    .o_count          (count),
`ifdef DISPATCH_PERF_EN
    .o_stall_full_cnt (sf_cnt),
    .o_stall_rs_cnt   (sr_cnt),
`endif
    .o_illegal_trap   (trap)
  );

  typedef struct {
    bit          ill;
    bit [1:0]    sel;
    bit [63:0]   uop;
  } mentry_t;

  mentry_t     q[$];
  bit          halted;
  int          n_cmp;
  int          n_err;
  int unsigned m_sf;
  int unsigned m_sr;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive after negedge, check before posedge, update model.
  task automatic step(input bit v, input bit [1:0] sel, input bit ill,
                      input bit [63:0] uop, input bit ar, input bit mr,
                      input bit lr, input bit fl);
    mentry_t h;
    bit live, e_rdy, e_alu, e_mul, e_ldst, e_trap;
    bit [63:0] e_uop;
    ifc.dec_valid   = v;
    ifc.dec_rs_sel  = sel;
    ifc.dec_illegal = ill;
    ifc.dec_uop     = uop;
    ifc.alu_ready   = ar;
    ifc.mul_ready   = mr;
    ifc.ldst_ready  = lr;
    flush           = fl;
    #1;
    h      = '{ill: 1'b0, sel: 2'd0, uop: 64'd0};
    if (q.size() > 0) h = q[0];
    live   = !halted && q.size() > 0;
    e_rdy  = !halted && q.size() < DEPTH;
    e_alu  = live && !h.ill && h.sel == 2'd1;
    e_mul  = live && !h.ill && h.sel == 2'd2;
    e_ldst = live && !h.ill && h.sel == 2'd3;
    e_trap = live && h.ill;
    e_uop  = (q.size() > 0) ? h.uop : 64'd0;
    check("dec_ready", 64'(ifc.dec_ready), 64'(e_rdy));
    check("alu_valid", 64'(ifc.alu_valid), 64'(e_alu));
    check("mul_valid", 64'(ifc.mul_valid), 64'(e_mul));
    check("ldst_valid", 64'(ifc.ldst_valid), 64'(e_ldst));
    check("uop", ifc.uop, e_uop);
    check("count", 64'(count), 64'(q.size()));
    check("trap", 64'(trap), 64'(e_trap));
    if (!halted && v && !e_rdy) m_sf++;
    if ((e_alu && !ar) || (e_mul && !mr) || (e_ldst && !lr)) m_sr++;
    @(posedge clk);
    if (fl) begin
      q.delete();
      halted = 1'b0;
    end else begin
      if (e_trap) halted = 1'b1;
      else if (live && (h.sel == 2'd0 || (e_alu && ar) ||
                        (e_mul && mr) || (e_ldst && lr)))
        void'(q.pop_front());
      if (v && e_rdy) q.push_back('{ill: ill, sel: sel, uop: uop});
    end
    @(negedge clk);
  endtask

  task automatic push(input bit [1:0] sel, input bit [63:0] uop,
                      input bit ar, input bit mr, input bit lr);
    step(1'b1, sel, 1'b0, uop, ar, mr, lr, 1'b0);
  endtask

  task automatic idle(input int n, input bit ar, input bit mr, input bit lr);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 64'd0, ar, mr, lr, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_sf  = 0;
    m_sr  = 0;
    halted = 1'b0;
    ifc.dec_valid   = 1'b0;
    ifc.dec_rs_sel  = '0;
    ifc.dec_illegal = 1'b0;
    ifc.dec_uop     = '0;
    ifc.alu_ready   = 1'b0;
    ifc.mul_ready   = 1'b0;
    ifc.ldst_ready  = 1'b0;
    #3;
    check("rst_count", 64'(count), 64'd0);
    check("rst_alu", 64'(ifc.alu_valid), 64'd0);
    check("rst_mul", 64'(ifc.mul_valid), 64'd0);
    check("rst_ldst", 64'(ifc.ldst_valid), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);
    check("rst_uop", ifc.uop, 64'd0);
    check("rst_ready", 64'(ifc.dec_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // ALU stream with ready high
    for (int i = 0; i < 4; i++) push(RS_ALU, 64'h11 + 64'(i), 1, 1, 1);
    idle(2, 1, 1, 1);

    // MUL backpressure until full, then drain
    for (int i = 0; i < 4; i++) push(RS_MUL, 64'h40 + 64'(i), 1, 0, 1);
    push(RS_ALU, 64'h99, 1, 0, 1);
    idle(2, 1, 0, 1);
    idle(5, 1, 1, 1);

    // strict order behind a blocked LDST head
    push(RS_LDST, 64'h51, 1, 1, 0);
    push(RS_ALU, 64'h52, 1, 1, 0);
    idle(2, 1, 1, 0);
    idle(3, 1, 1, 1);

    // RS_NONE dropped silently
    push(RS_NONE, 64'h21, 1, 1, 1);
    push(RS_ALU, 64'h22, 1, 1, 1);
    idle(2, 1, 1, 1);

    // illegal head halts until flush
    push(RS_ALU, 64'h31, 1, 1, 1);
    step(1'b1, RS_ALU, 1'b1, 64'hdead, 1, 1, 1, 1'b0);
    push(RS_ALU, 64'h32, 1, 1, 1);
    idle(4, 1, 1, 1);
    step(1'b0, 2'd0, 1'b0, 64'd0, 1, 1, 1, 1'b1);
    idle(2, 1, 1, 1);

    // flush with a simultaneous push
    for (int i = 0; i < 3; i++) push(RS_ALU, 64'h60 + 64'(i), 0, 1, 1);
    step(1'b1, RS_ALU, 1'b0, 64'h6f, 0, 1, 1, 1'b1);
    idle(2, 1, 1, 1);

    // asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) push(RS_ALU, 64'h70 + 64'(i), 0, 1, 1);
    ifc.alu_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_alu", 64'(ifc.alu_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_uop", ifc.uop, 64'd0);
    q.delete();
    halted = 1'b0;
    m_sf = 0;
    m_sr = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(1, 1, 1, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 16) == 0,
           {$urandom, $urandom}, ($urandom % 3) != 0, ($urandom % 3) != 0,
           ($urandom % 3) != 0, ($urandom % 24) == 0);
    end
    idle(1, 1, 1, 1);

`ifdef DISPATCH_PERF_EN
    check("stall_full", 64'(sf_cnt), 64'(m_sf));
    check("stall_rs", 64'(sr_cnt), 64'(m_sr));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- In-order dispatch queue and scheduler between the instruction decoder and the three reservation stations (ALU, MUL, LDST).
- Buffers decoded micro-ops and steers the head entry to the station named by its rs_sel field, one dispatch per cycle, honouring per-station ready backpressure.
- Handles illegal instructions by halting dispatch until a pipeline flush.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- UOP_WIDTH, 64, width of the packed decoded micro-op payload.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_flush  in  1  discard all queued entries; leave HALT
- i_dec_valid  in  1  decoder presents a micro-op
- o_dec_ready  out  1  queue accepts a micro-op this cycle
- i_dec_uop  in  UOP_WIDTH  packed micro-op payload
- i_dec_rs_sel  in  RS_SEL  target station
- i_dec_illegal  in  1  decoder illegal flag
- o_alu_valid  out  1  head is dispatching to ALU station
- i_alu_ready  in  1  ALU station can accept
- o_mul_valid  out  1  head is dispatching to MUL station
- i_mul_ready  in  1  MUL station can accept
- o_ldst_valid  out  1  head is dispatching to LDST station
- i_ldst_ready  in  1  LDST station can accept
- o_uop  out  UOP_WIDTH  head payload, shared by all stations
- o_count  out  CNT_W  current occupancy
- o_illegal_trap  out  1  one-cycle pulse when an illegal entry reaches the head

Behaviour:
- Reset: queue empty, pointers 0, o_count=0, state RUN, o_illegal_trap=0. All o_*_valid=0. o_uop=0 when empty.
- Storage: circular buffer with head/tail pointers that wrap at DEPTH. Each entry holds {illegal, rs_sel, uop}.
- Enqueue: on i_dec_valid && o_dec_ready at a clock edge.
- o_dec_ready = (state==RUN) && (o_count<DEPTH). It does not depend on any station ready.
  - When full, enqueue is blocked even if the head dispatches in the same cycle.
- Latency: an entry enqueued at edge N is visible at the head no earlier than after edge N (registered, no bypass).
- Head handling in RUN with queue non-empty:
  - rs_sel=RS_ALU/RS_MUL/RS_LDST with illegal=0: assert only the matching o_*_valid. Dequeue on valid&&ready. Valid never depends on ready, and a held head stays stable until accepted.
  - rs_sel=RS_NONE with illegal=0: silently dropped, one dequeue per cycle, no valid asserted.
  - illegal=1: no valid asserted and entry not dequeued. Pulse o_illegal_trap for exactly one cycle, then go to HALT.
- States:
  - RUN -> HALT on an illegal head.
  - HALT -> RUN on i_flush.
  - HALT: o_dec_ready=0, all valid=0, queue frozen.
- Simultaneous enqueue and dequeue when not full: o_count unchanged, both pointers advance.
- i_flush (any state): highest priority. At the edge, pointers and count clear and state becomes RUN.
  - An enqueue in the flush cycle is dropped.
  - Valids may be high in the flush cycle. A station that samples them must qualify with flush itself; this block does not retract them.
- Reset mid-operation: asynchronous clear to reset state regardless of handshake.

Optional Feature:
- Macro DISPATCH_PERF_EN.
- When defined, adds outputs o_stall_full_cnt[31:0] (cycles with i_dec_valid && !o_dec_ready in RUN) and o_stall_rs_cnt[31:0] (cycles with any o_*_valid && !matching ready).
  - Both saturate at all-ones, reset to 0, and are not cleared by flush.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared constants package/header holds RS_SEL width (2) and the encodings RS_NONE=0, RS_ALU=1, RS_MUL=2, RS_LDST=3, used by both the decoder and this block. UOP_WIDTH also lives there.
- One natural sub-module: dispatch_fifo, a generic DEPTH x W circular buffer with push/pop/flush/count.
- dispatch_ctrl holds the HALT FSM, steering and trap logic.

Test Plan:
- Push 4 ALU uops, payloads 0x11..0x14, with i_alu_ready=1 -> o_alu_valid on 4 consecutive cycles starting one cycle after the first push, o_uop 0x11..0x14 in order, o_count returns to 0.
- Push 4 MUL uops with i_mul_ready=0 -> o_count=4, o_dec_ready=0, o_mul_valid held with o_uop stable. Raise ready -> drains in 4 cycles, ready reasserts once o_count<4.
- Head LDST blocked (i_ldst_ready=0), ALU entry behind it with i_alu_ready=1 -> ALU entry not dispatched until the LDST entry is accepted (strict order).
- Push RS_NONE, then ALU 0x22 -> no valid for RS_NONE, ALU 0x22 dispatched the following cycle.
- Push ALU 0x31, illegal, ALU 0x32 -> 0x31 dispatched; o_illegal_trap high exactly 1 cycle; o_dec_ready=0; 0x32 never dispatched. Assert i_flush -> o_count=0, state RUN, ready=1 the next cycle.
- Flush with 3 entries queued and a simultaneous push -> o_count=0 after the edge and the pushed uop is not dispatched. Assert rst asynchronously mid-drain -> all valids and o_count go to 0 immediately.
